maple_bit_deserializer: RTL and testbench

Data-phase stage of the Maple bus receiver. It sits between the start-frame decoder and the end-frame decoder, shares their synchronized SDCKA/SDCKB edge pulses, and turns the alternating-clock data bits into an MSB-first byte stream. Bytes leave on a valid/ready interface, and the final byte of a frame carries `m_tlast`. Frame-level faults (partial byte, end-frame error, restart, timeout) are reported on `rx_error`.

---
 rtl/maple_rx_pkg.sv | 23 ++
 rtl/maple_rx_out_reg.sv | 69 ++++++
 rtl/maple_bit_deserializer.sv | 199 +++++++++++++++++++
 tb/tb_maple_bit_deserializer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_rx_pkg.sv
// -----------------------------------------------------------------------------
// maple_rx_pkg
// Shared definitions for the Maple bus receiver data-phase stage: the one-hot
// state encoding, byte width, bit-counter terminal value and the default
// inter-edge timeout.
// -----------------------------------------------------------------------------
package maple_rx_pkg;

   localparam int BYTE_W = 8;
   localparam int BIT_CNT_W = 3;

   // Value of the bit counter while the 8th bit of a byte is being shifted in.
   localparam logic [BIT_CNT_W-1:0] LAST_BIT_IDX = BIT_CNT_W'(BYTE_W - 1);

   localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd50000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'b001,
      ST_RECEIVING = 3'b010,
      ST_TRAILER   = 3'b100
   } rxState_t;

endpackage

// File: rtl/maple_rx_out_reg.sv
// -----------------------------------------------------------------------------
// maple_rx_out_reg
// Output holding register of the Maple receiver. Presents one byte on a
// valid/ready interface together with its tlast flag. A push while the held
// byte is still waiting (valid and not ready) drops the new byte and pulses
// overrun for one cycle.
//
// Ports
//   aclk        in   clock
//   aresetn     in   synchronous active-low reset
//   i_push      in   load request for a new byte
//   i_pushData  in   byte to load
//   i_pushLast  in   tlast flag of the byte to load
//   i_ready     in   consumer accepts the held byte this cycle
//   o_data      out  held byte
//   o_valid     out  held byte is valid
//   o_last      out  held byte is the last of its frame
//   o_overrun   out  one-cycle pulse: pushed byte was dropped
// -----------------------------------------------------------------------------
module maple_rx_out_reg
   import maple_rx_pkg::*;
(
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              i_push,
   input  logic [BYTE_W-1:0] i_pushData,
   input  logic              i_pushLast,
   input  logic              i_ready,
   output logic [BYTE_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_last,
   output logic              o_overrun
);

   logic [BYTE_W-1:0] r_data;
   logic              r_valid;
   logic              r_last;
   logic              r_overrun;

   // The register is free when empty or being drained this same cycle; a push
   // into a stalled register keeps the old byte and flags the loss instead.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (i_push) begin
            if (!r_valid || i_ready) begin
               r_data  <= i_pushData;
               r_last  <= i_pushLast;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_last    = r_last;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/maple_bit_deserializer.sv
// -----------------------------------------------------------------------------
// maple_bit_deserializer
// Data-phase stage of the Maple bus receiver. Bits arrive on alternating
// SDCKA/SDCKB falling edges: on an expected A edge the level of SDCKB is the
// data bit, on an expected B edge the level of SDCKA. Bits are assembled MSB
// first. Each completed byte waits in a one-byte pending buffer until either
// the next byte completes (pushed with tlast=0) or end_frame arrives (pushed
// with tlast=1), so the final byte of a frame can be tagged.
//
// Ports
//   aclk, aresetn                 clock, synchronous active-low reset
//   sdcka_in, sdckb_in            synchronized line levels
//   sdcka_negedge, sdckb_negedge  one-cycle falling-edge pulses
//   start_frame                   start-frame decoder pulse
//   end_frame, end_frame_error    end-frame decoder pulses
//   m_tdata, m_tvalid, m_tlast    byte stream out
//   m_tready                      consumer ready
//   rx_error                      one-cycle pulse: frame fault
//   overrun                       one-cycle pulse: byte dropped at output
//   busy                          high whenever a frame is open
// -----------------------------------------------------------------------------
module maple_bit_deserializer
   import maple_rx_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              sdcka_in,
   input  logic              sdckb_in,
   input  logic              sdcka_negedge,
   input  logic              sdckb_negedge,
   input  logic              start_frame,
   input  logic              end_frame,
   input  logic              end_frame_error,
   output logic [BYTE_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              rx_error,
   output logic              overrun,
   output logic              busy
);

   rxState_t               r_state;
   rxState_t               w_nextState;

   logic [BYTE_W-1:0]      r_shreg;
   logic [BIT_CNT_W-1:0]   r_bitCnt;
   logic                   r_expectA;
   logic [BYTE_W-1:0]      r_pendData;
   logic                   r_pendFull;
   logic [15:0]            r_timeoutCnt;
   logic                   r_rxError;

   logic                   w_expectedEdge;
   logic                   w_unexpectedEdge;
   logic                   w_sampleBit;
   logic [BYTE_W-1:0]      w_shregNext;
   logic                   w_byteDone;
   logic                   w_timeout;
   logic                   w_shiftEn;
   logic                   w_clearFrame;
   logic                   w_push;
   logic                   w_pushLast;
   logic                   w_rxErrorNext;

   // An edge on the line we are not waiting for (including both lines at once)
   // is the start of the end pattern, so it is checked before the expected one.
   assign w_expectedEdge   = r_expectA ? sdcka_negedge : sdckb_negedge;
   assign w_unexpectedEdge = r_expectA ? sdckb_negedge : sdcka_negedge;
   assign w_sampleBit      = r_expectA ? sdckb_in : sdcka_in;
   assign w_shregNext      = {r_shreg[BYTE_W-2:0], w_sampleBit};
   assign w_byteDone       = (r_bitCnt == LAST_BIT_IDX);
   assign w_timeout        = (r_state != ST_IDLE) && (r_timeoutCnt == TIMEOUT_CYCLES);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Frame-level aborts (restart, end-frame error, timeout) take priority over
   // anything the current state would do. start_frame is first so it also wins
   // over a coincident end_frame.
   always_comb begin
      w_nextState   = r_state;
      w_shiftEn     = 1'b0;
      w_clearFrame  = 1'b0;
      w_push        = 1'b0;
      w_pushLast    = 1'b0;
      w_rxErrorNext = 1'b0;

      if (r_state == ST_IDLE) begin
         if (start_frame) begin
            w_nextState  = ST_RECEIVING;
            w_clearFrame = 1'b1;
         end
      end else if (start_frame) begin
         w_rxErrorNext = 1'b1;
         w_nextState   = ST_RECEIVING;
         w_clearFrame  = 1'b1;
      end else if (end_frame_error || w_timeout) begin
         w_rxErrorNext = 1'b1;
         w_nextState   = ST_IDLE;
         w_clearFrame  = 1'b1;
      end else begin
         case (r_state)
            ST_RECEIVING: begin
               if (w_unexpectedEdge) begin
                  w_nextState = ST_TRAILER;
               end else if (w_expectedEdge) begin
                  w_shiftEn = 1'b1;
                  if (w_byteDone && r_pendFull) begin
                     w_push = 1'b1;
                  end
               end
            end
            ST_TRAILER: begin
               if (end_frame) begin
                  w_nextState  = ST_IDLE;
                  w_clearFrame = 1'b1;
                  if (r_bitCnt != '0) begin
                     w_rxErrorNext = 1'b1;
                  end else if (r_pendFull) begin
                     w_push     = 1'b1;
                     w_pushLast = 1'b1;
                  end
               end
            end
            default: begin
               w_nextState  = ST_IDLE;
               w_clearFrame = 1'b1;
            end
         endcase
      end
   end

   // A completing byte goes straight into pending in the same cycle the older
   // pending byte is pushed out, so the buffer never needs an empty gap.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_shreg    <= '0;
         r_bitCnt   <= '0;
         r_expectA  <= 1'b1;
         r_pendData <= '0;
         r_pendFull <= 1'b0;
         r_rxError  <= 1'b0;
      end else begin
         r_rxError <= w_rxErrorNext;
         if (w_clearFrame) begin
            r_shreg    <= '0;
            r_bitCnt   <= '0;
            r_expectA  <= 1'b1;
            r_pendFull <= 1'b0;
         end else if (w_shiftEn) begin
            r_shreg   <= w_shregNext;
            r_bitCnt  <= r_bitCnt + BIT_CNT_W'(1);
            r_expectA <= ~r_expectA;
            if (w_byteDone) begin
               r_pendData <= w_shregNext;
               r_pendFull <= 1'b1;
            end
         end
      end
   end

   // Idle time since the last accepted edge or state change. A restart does
   // not change the state, so a frame clear also restarts the count.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_timeoutCnt <= '0;
      end else if ((r_state == ST_IDLE) || (w_nextState != r_state) || w_shiftEn || w_clearFrame) begin
         r_timeoutCnt <= '0;
      end else begin
         r_timeoutCnt <= r_timeoutCnt + 16'd1;
      end
   end

   maple_rx_out_reg u_outReg (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .i_push     (w_push),
      .i_pushData (r_pendData),
      .i_pushLast (w_pushLast),
      .i_ready    (m_tready),
      .o_data     (m_tdata),
      .o_valid    (m_tvalid),
      .o_last     (m_tlast),
      .o_overrun  (overrun)
   );

   assign rx_error = r_rxError;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_maple_bit_deserializer.sv
// -----------------------------------------------------------------------------
// tb_maple_bit_deserializer
// Directed testbench for the Maple receiver data-phase stage. Frames are built
// from individual alternating-line bits; expected bytes, flags and pulse
// timing are written out by hand for each scenario.
// -----------------------------------------------------------------------------
module tb_maple_bit_deserializer;

   localparam logic [15:0] TB_TIMEOUT = 16'd100;

   logic       aclk;
   logic       aresetn;
   logic       sdcka_in;
   logic       sdckb_in;
   logic       sdcka_negedge;
   logic       sdckb_negedge;
   logic       start_frame;
   logic       end_frame;
   logic       end_frame_error;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready;
   logic       m_tlast;
   logic       rx_error;
   logic       overrun;
   logic       busy;

   int testCount = 0;
   int failCount = 0;

   // Bench-side view of which line carries the next expected falling edge.
   logic expectA = 1'b1;

   // Pulse and handshake history, sampled on the falling clock edge.
   int   rxErrCount   = 0;
   int   overrunCount = 0;
   int   validCount   = 0;
   logic [7:0] logData[$];
   logic       logLast[$];

   maple_bit_deserializer #(
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .sdcka_in        (sdcka_in),
      .sdckb_in        (sdckb_in),
      .sdcka_negedge   (sdcka_negedge),
      .sdckb_negedge   (sdckb_negedge),
      .start_frame     (start_frame),
      .end_frame       (end_frame),
      .end_frame_error (end_frame_error),
      .m_tdata         (m_tdata),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_tlast         (m_tlast),
      .rx_error        (rx_error),
      .overrun         (overrun),
      .busy            (busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(negedge aclk) begin
      if (rx_error === 1'b1) rxErrCount++;
      if (overrun === 1'b1) overrunCount++;
      if (m_tvalid === 1'b1) validCount++;
      if ((m_tvalid === 1'b1) && (m_tready === 1'b1)) begin
         logData.push_back(m_tdata);
         logLast.push_back(m_tlast);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Drive one cycle of decoder/edge pulses, then return them to zero.
   task automatic applyStimulus(input logic aNeg, input logic bNeg, input logic sf,
                                input logic ef, input logic efe);
      sdcka_negedge   = aNeg;
      sdckb_negedge   = bNeg;
      start_frame     = sf;
      end_frame       = ef;
      end_frame_error = efe;
      tick();
      sdcka_negedge   = 1'b0;
      sdckb_negedge   = 1'b0;
      start_frame     = 1'b0;
      end_frame       = 1'b0;
      end_frame_error = 1'b0;
   endtask

   task automatic startFrame();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expectA = 1'b1;
   endtask

   task automatic sendBit(input logic b);
      if (expectA) begin
         sdckb_in = b;
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
         sdcka_in = b;
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      expectA = ~expectA;
   endtask

   task automatic sendByte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) sendBit(v[i]);
   endtask

   // Falling edge on the line that is not expected: start of the end pattern.
   task automatic endPattern();
      if (expectA) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic endFrame();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic clearLog();
      rxErrCount   = 0;
      overrunCount = 0;
      validCount   = 0;
      logData.delete();
      logLast.delete();
   endtask

   // Returns {tlast, data} of the idx-th accepted byte, or 9'h1FF if absent.
   function automatic logic [8:0] logged(input int idx);
      if (idx < logData.size()) return {logLast[idx], logData[idx]};
      return 9'h1FF;
   endfunction

   initial begin
      aresetn = 1'b0;
      sdcka_in = 1'b1;
      sdckb_in = 1'b1;
      sdcka_negedge = 1'b0;
      sdckb_negedge = 1'b0;
      start_frame = 1'b0;
      end_frame = 1'b0;
      end_frame_error = 1'b0;
      m_tready = 1'b1;

      // Reset values
      repeat (3) tick();
      checkOutput("rst_tdata", m_tdata, 8'h00);
      checkOutput("rst_tvalid", m_tvalid, 1'b0);
      checkOutput("rst_tlast", m_tlast, 1'b0);
      checkOutput("rst_rx_error", rx_error, 1'b0);
      checkOutput("rst_overrun", overrun, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      aresetn = 1'b1;
      tick();

      // Frame 0xA5, 0x3C with the consumer always ready
      clearLog();
      m_tready = 1'b1;
      startFrame();
      checkOutput("f1_busy_rise", busy, 1'b1);
      sendByte(8'hA5);
      checkOutput("f1_first_held", m_tvalid, 1'b0);
      sendByte(8'h3C);
      checkOutput("f1_b0_valid", m_tvalid, 1'b1);
      checkOutput("f1_b0_data", m_tdata, 8'hA5);
      checkOutput("f1_b0_last", m_tlast, 1'b0);
      endPattern();
      checkOutput("f1_drained", m_tvalid, 1'b0);
      endFrame();
      checkOutput("f1_b1_valid", m_tvalid, 1'b1);
      checkOutput("f1_b1_data", m_tdata, 8'h3C);
      checkOutput("f1_b1_last", m_tlast, 1'b1);
      checkOutput("f1_busy_fall", busy, 1'b0);
      tick();
      checkOutput("f1_log0", logged(0), {1'b0, 8'hA5});
      checkOutput("f1_log1", logged(1), {1'b1, 8'h3C});
      checkOutput("f1_log_size", logData.size(), 2);
      checkOutput("f1_rx_errors", rxErrCount, 0);

      // Same frame with the consumer stalled
      clearLog();
      m_tready = 1'b0;
      startFrame();
      sendByte(8'hA5);
      sendByte(8'h3C);
      checkOutput("f2_b0_valid", m_tvalid, 1'b1);
      endPattern();
      endFrame();
      checkOutput("f2_overrun_pulse", overrun, 1'b1);
      checkOutput("f2_held_data", m_tdata, 8'hA5);
      checkOutput("f2_held_last", m_tlast, 1'b0);
      tick();
      checkOutput("f2_overrun_cleared", overrun, 1'b0);
      checkOutput("f2_still_valid", m_tvalid, 1'b1);
      m_tready = 1'b1;
      tick();
      checkOutput("f2_drained", m_tvalid, 1'b0);
      checkOutput("f2_log0", logged(0), {1'b0, 8'hA5});
      checkOutput("f2_log_size", logData.size(), 1);
      checkOutput("f2_overrun_count", overrunCount, 1);
      checkOutput("f2_rx_errors", rxErrCount, 0);

      // 12 bits then end: partial byte
      clearLog();
      startFrame();
      sendByte(8'hF0);
      for (int i = 0; i < 4; i++) sendBit(i[0]);
      endPattern();
      endFrame();
      checkOutput("f3_rx_error", rx_error, 1'b1);
      checkOutput("f3_busy", busy, 1'b0);
      tick();
      checkOutput("f3_rx_error_count", rxErrCount, 1);
      checkOutput("f3_no_valid", validCount, 0);

      // Two bytes then end_frame_error
      clearLog();
      startFrame();
      sendByte(8'h5A);
      sendByte(8'hC3);
      checkOutput("f4_b0_data", m_tdata, 8'h5A);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("f4_rx_error", rx_error, 1'b1);
      checkOutput("f4_busy", busy, 1'b0);
      repeat (3) tick();
      checkOutput("f4_log0", logged(0), {1'b0, 8'h5A});
      checkOutput("f4_log_size", logData.size(), 1);
      checkOutput("f4_rx_error_count", rxErrCount, 1);

      // Three bits then silence until timeout
      clearLog();
      startFrame();
      sendBit(1'b1);
      sendBit(1'b1);
      sendBit(1'b0);
      repeat (TB_TIMEOUT) tick();
      checkOutput("f5_no_early_error", rx_error, 1'b0);
      checkOutput("f5_busy_before", busy, 1'b1);
      tick();
      checkOutput("f5_timeout_error", rx_error, 1'b1);
      checkOutput("f5_busy_after", busy, 1'b0);
      tick();
      checkOutput("f5_rx_error_count", rxErrCount, 1);

      // Restart after 5 bits, then a clean 0x81 frame
      clearLog();
      startFrame();
      for (int i = 0; i < 5; i++) sendBit(1'b1);
      startFrame();
      checkOutput("f6_restart_error", rx_error, 1'b1);
      checkOutput("f6_busy", busy, 1'b1);
      sendByte(8'h81);
      endPattern();
      endFrame();
      checkOutput("f6_data", m_tdata, 8'h81);
      checkOutput("f6_last", m_tlast, 1'b1);
      tick();
      checkOutput("f6_log0", logged(0), {1'b1, 8'h81});
      checkOutput("f6_log_size", logData.size(), 1);
      checkOutput("f6_rx_error_count", rxErrCount, 1);

      // Empty frame: end pattern straight after start
      clearLog();
      startFrame();
      endPattern();
      endFrame();
      checkOutput("f7_busy", busy, 1'b0);
      tick();
      checkOutput("f7_no_valid", validCount, 0);
      checkOutput("f7_no_error", rxErrCount, 0);

      // Simultaneous A and B edges act as the end pattern
      clearLog();
      startFrame();
      sendByte(8'h77);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      endFrame();
      checkOutput("f8_data", m_tdata, 8'h77);
      checkOutput("f8_last", m_tlast, 1'b1);
      checkOutput("f8_valid", m_tvalid, 1'b1);
      tick();
      checkOutput("f8_log_size", logData.size(), 1);

      // Reset mid-frame drops the held byte
      clearLog();
      m_tready = 1'b0;
      startFrame();
      sendByte(8'h11);
      sendByte(8'h22);
      checkOutput("f9_held_valid", m_tvalid, 1'b1);
      aresetn = 1'b0;
      tick();
      checkOutput("f9_rst_valid", m_tvalid, 1'b0);
      checkOutput("f9_rst_data", m_tdata, 8'h00);
      checkOutput("f9_rst_busy", busy, 1'b0);
      aresetn = 1'b1;
      m_tready = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
